// File: rtl/ov7670_frame_capture_pkg.sv
// rtl/ov7670_frame_capture_pkg.sv - shared types for the OV7670 capture path
package CameraCaptureTypes;

  localparam int QUEUE_WORD_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    FRAME,
    DROP
  } capture_state_t;

  typedef struct packed {
    logic        sof;
    logic [15:0] rgb565;
  } queue_word_t;

endpackage

// File: rtl/ov7670_frame_capture_packer.sv
// rtl/ov7670_frame_capture_packer.sv - pairs camera bytes into RGB565 pixels (high byte first)
module rgb565_byte_packer (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        href_i,
  input  logic [7:0]  data_i,
  output logic        pixel_valid_o,
  output logic [15:0] pixel_o
);

  logic       phase_q, phase_d;
  logic [7:0] hi_q, hi_d;

  // Dropping href resets the phase so an odd trailing byte never pairs with the next line.
  always_comb begin
    phase_d = href_i ? ~phase_q : 1'b0;
    hi_d    = (href_i && !phase_q) ? data_i : hi_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 1'b0;
      hi_q    <= 8'h00;
    end else begin
      phase_q <= phase_d;
      hi_q    <= hi_d;
    end
  end

  assign pixel_valid_o = href_i & phase_q;
  assign pixel_o       = {hi_q, data_i};

endmodule

// File: rtl/ov7670_frame_capture.sv
// rtl/ov7670_frame_capture.sv - OV7670 frame capture into the 17-bit camera FIFO
// Optional line/frame geometry checker: CAPTURE_LINE_CHECK_EN.
module ov7670_frame_capture
  import CameraCaptureTypes::*;
#(
  parameter int FRAME_WIDTH       = 640,
  parameter int FRAME_HEIGHT      = 480,
  parameter bit VSYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    cam_vsync,
  input  logic                    cam_href,
  input  logic [7:0]              cam_data,
  input  logic                    queue_full,
  output logic [QUEUE_WORD_W-1:0] queue_data,
  output logic                    queue_wr_en,
  output logic                    queue_wr_clk,
  output logic                    frame_done,
  output logic                    overflow,
  output logic                    busy
`ifdef CAPTURE_LINE_CHECK_EN
  , output logic                  line_error
`endif
);

  localparam int COL_W = $clog2(FRAME_WIDTH + 1);
  localparam int ROW_W = $clog2(FRAME_HEIGHT + 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(FRAME_WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(FRAME_HEIGHT);

  capture_state_t state_q, state_d;
  logic vsync_q, href_q, vs_prev_q, href_prev_q;
  logic [7:0] data_q;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic sof_pending_q, sof_pending_d;
  logic wr_en_q, wr_en_d, frame_done_q, frame_done_d, overflow_q, overflow_d;
  queue_word_t word_q, word_d;

  logic pix_valid;
  logic [15:0] pixel;

  rgb565_byte_packer u_packer (
    .clk_i        (clk),
    .rst_ni       (reset_n),
    .href_i       (href_q),
    .data_i       (data_q),
    .pixel_valid_o(pix_valid),
    .pixel_o      (pixel)
  );

  logic vs_act, vs_rise, vs_fall, href_fall, capturing, frame_start, line_end;
  logic in_window, do_write, pix_blocked;

  assign vs_act      = ~(vsync_q ^ VSYNC_ACTIVE_HIGH);
  assign vs_rise     = vs_act & ~vs_prev_q;
  assign vs_fall     = ~vs_act & vs_prev_q;
  assign href_fall   = ~href_q & href_prev_q;
  assign capturing   = (state_q == FRAME) || (state_q == DROP);
  assign frame_start = (state_q == WAIT_START) && vs_fall;
  assign line_end    = capturing && href_fall && (col_q != '0);
  assign in_window   = (col_q < COL_MAX) && (row_q < ROW_MAX);
  assign do_write    = (state_q == FRAME) && pix_valid && in_window && !queue_full;
  assign pix_blocked = (state_q == FRAME) && pix_valid && queue_full;

  // Input registers reset to the inactive vsync level so release never fakes an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q     <= ~VSYNC_ACTIVE_HIGH;
      href_q      <= 1'b0;
      data_q      <= 8'h00;
      vs_prev_q   <= 1'b0;
      href_prev_q <= 1'b0;
    end else begin
      vsync_q     <= cam_vsync;
      href_q      <= cam_href;
      data_q      <= cam_data;
      vs_prev_q   <= vs_act;
      href_prev_q <= href_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:       if (enable && vs_act) state_d = WAIT_START;
      WAIT_START: if (vs_fall) state_d = FRAME;
      FRAME, DROP: begin
        if (vs_rise)          state_d = enable ? WAIT_START : IDLE;
        else if (pix_blocked) state_d = DROP;
      end
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d       = do_write;
    word_d        = do_write ? queue_word_t'({sof_pending_q, pixel}) : word_q;
    frame_done_d  = capturing && vs_rise;
    overflow_d    = overflow_q;
    sof_pending_d = sof_pending_q;
    col_d         = col_q;
    row_d         = row_q;
    if (do_write && sof_pending_q) overflow_d = 1'b0;
    else if (pix_blocked)          overflow_d = 1'b1;
    if (frame_start)   sof_pending_d = 1'b1;
    else if (do_write) sof_pending_d = 1'b0;
    if (frame_start) begin
      col_d = '0;
      row_d = '0;
    end else if (line_end) begin
      col_d = '0;
      row_d = (row_q == ROW_MAX) ? row_q : row_q + 1'b1;
    end else if (capturing && pix_valid) begin
      col_d = (col_q == COL_MAX) ? col_q : col_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_en_q       <= 1'b0;
      word_q        <= '0;
      frame_done_q  <= 1'b0;
      overflow_q    <= 1'b0;
      sof_pending_q <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
    end else begin
      wr_en_q       <= wr_en_d;
      word_q        <= word_d;
      frame_done_q  <= frame_done_d;
      overflow_q    <= overflow_d;
      sof_pending_q <= sof_pending_d;
      col_q         <= col_d;
      row_q         <= row_d;
    end
  end

`ifdef CAPTURE_LINE_CHECK_EN
  // Counters saturate, so overrun flags remember that the true count went past the limit.
  logic col_over_q, col_over_d, row_over_q, row_over_d, line_err_q, line_err_d;

  always_comb begin
    col_over_d = col_over_q;
    row_over_d = row_over_q;
    line_err_d = line_err_q;
    if (frame_start) begin
      col_over_d = 1'b0;
      row_over_d = 1'b0;
    end else if (line_end) begin
      col_over_d = 1'b0;
      if (row_q == ROW_MAX) row_over_d = 1'b1;
    end else if (capturing && pix_valid && col_q == COL_MAX) begin
      col_over_d = 1'b1;
    end
    if (do_write && sof_pending_q) line_err_d = 1'b0;
    if (line_end && (col_q != COL_MAX || col_over_q)) line_err_d = 1'b1;
    if (capturing && vs_rise && (row_q != ROW_MAX || row_over_q)) line_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_over_q <= 1'b0;
      row_over_q <= 1'b0;
      line_err_q <= 1'b0;
    end else begin
      col_over_q <= col_over_d;
      row_over_q <= row_over_d;
      line_err_q <= line_err_d;
    end
  end

  assign line_error = line_err_q;
`endif

  assign queue_data   = word_q;
  assign queue_wr_en  = wr_en_q;
  assign queue_wr_clk = clk;
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ov7670_frame_capture.sv
// tb/tb_ov7670_frame_capture.sv - directed bench for ov7670_frame_capture (8x4 frame)
module tb_ov7670_frame_capture;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        cam_vsync = 1'b1;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        queue_full = 1'b0;
  logic [16:0] queue_data;
  logic        queue_wr_en, queue_wr_clk, frame_done, overflow, busy;
`ifdef CAPTURE_LINE_CHECK_EN
  logic        line_error;
`endif

  int n_checks = 0;
  int n_pass = 0;
  logic [16:0] wr_log[$];
  int done_cnt = 0;
  int full_at = 0;
  int pix_idx = 0;

  always #5 clk = ~clk;

  ov7670_frame_capture #(
    .FRAME_WIDTH      (8),
    .FRAME_HEIGHT     (4),
    .VSYNC_ACTIVE_HIGH(1'b1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .cam_vsync   (cam_vsync),
    .cam_href    (cam_href),
    .cam_data    (cam_data),
    .queue_full  (queue_full),
    .queue_data  (queue_data),
    .queue_wr_en (queue_wr_en),
    .queue_wr_clk(queue_wr_clk),
    .frame_done  (frame_done),
    .overflow    (overflow),
    .busy        (busy)
`ifdef CAPTURE_LINE_CHECK_EN
    , .line_error(line_error)
`endif
  );

  always @(negedge clk) begin
    if (queue_wr_en) wr_log.push_back(queue_data);
    if (frame_done) done_cnt++;
  end

  task automatic send_line(input int npix, input logic [7:0] hi, input logic [7:0] lo);
    for (int p = 0; p < npix; p++) begin
      @(negedge clk); cam_href = 1'b1; cam_data = hi;
      @(negedge clk); cam_data = lo;
      pix_idx++;
      if (pix_idx == full_at) queue_full = 1'b1;
    end
    @(negedge clk); cam_href = 1'b0; cam_data = 8'h00;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_start();
    repeat (3) @(negedge clk);
    @(negedge clk); cam_vsync = 1'b0; pix_idx = 0;
    repeat (3) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk); cam_vsync = 1'b1;
    repeat (5) @(negedge clk);
    queue_full = 1'b0;
  endtask

  task automatic send_frame(input int nlines, input int npix, input logic [7:0] hi, input logic [7:0] lo);
    frame_start();
    for (int l = 0; l < nlines; l++) send_line(npix, hi, lo);
    frame_end();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++; if (queue_wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", queue_wr_en); else n_pass++;
    n_checks++; if (queue_data !== 17'h0) $display("FAIL reset_data: got %h want 00000", queue_data); else n_pass++;
    n_checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL reset_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_basic_frame();
    int base, d0, bad, sofs;
    logic [16:0] first;
    enable = 1'b1;
    base = wr_log.size(); d0 = done_cnt;
    send_frame(4, 8, 8'hF8, 8'h00);
    first = (wr_log.size() > base) ? wr_log[base] : 17'h0;
    bad = 0; sofs = 0;
    for (int i = base; i < wr_log.size(); i++) begin
      if (wr_log[i][15:0] !== 16'hF800) bad++;
      if (wr_log[i][16]) sofs++;
    end
    n_checks++; if (wr_log.size() - base !== 32) $display("FAIL basic_count: got %0d want 32", wr_log.size() - base); else n_pass++;
    n_checks++; if (first !== 17'h1F800) $display("FAIL basic_first: got %h want 1f800", first); else n_pass++;
    n_checks++; if (bad !== 0) $display("FAIL basic_pixels: got %0d bad words want 0", bad); else n_pass++;
    n_checks++; if (sofs !== 1) $display("FAIL basic_sof_count: got %0d want 1", sofs); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL basic_frame_done: got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL basic_overflow: got %b want 0", overflow); else n_pass++;
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
  endtask

  task automatic test_latency();
    int base;
    base = wr_log.size();
    frame_start();
    send_line(8, 8'hF8, 8'h00);
    @(negedge clk); cam_href = 1'b1; cam_data = 8'hAB;
    @(negedge clk); cam_data = 8'hCD;
    @(negedge clk);
    n_checks++; if (queue_wr_en !== 1'b0) $display("FAIL lat_early: got %b want 0", queue_wr_en); else n_pass++;
    cam_href = 1'b0; cam_data = 8'h00;
    @(negedge clk);
    n_checks++; if (queue_wr_en !== 1'b1) $display("FAIL lat_wr_en: got %b want 1", queue_wr_en); else n_pass++;
    n_checks++; if (queue_data !== 17'h0ABCD) $display("FAIL lat_data: got %h want 0abcd", queue_data); else n_pass++;
    repeat (3) @(negedge clk);
    send_line(8, 8'hF8, 8'h00);
    send_line(8, 8'hF8, 8'h00);
    frame_end();
    n_checks++; if (wr_log.size() - base !== 25) $display("FAIL lat_count: got %0d want 25", wr_log.size() - base); else n_pass++;
  endtask

  task automatic test_oversize();
    int base, d0;
    base = wr_log.size(); d0 = done_cnt;
    send_frame(5, 10, 8'h12, 8'h34);
    n_checks++; if (wr_log.size() - base !== 32) $display("FAIL over_count: got %0d want 32", wr_log.size() - base); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL over_frame_done: got %0d want 1", done_cnt - d0); else n_pass++;
`ifdef CAPTURE_LINE_CHECK_EN
    n_checks++; if (line_error !== 1'b1) $display("FAIL over_line_error: got %b want 1", line_error); else n_pass++;
`endif
  endtask

  task automatic test_overflow();
    int base, d0;
    logic [16:0] first;
    full_at = 5;
    base = wr_log.size(); d0 = done_cnt;
    send_frame(4, 8, 8'hF8, 8'h00);
    n_checks++; if (wr_log.size() - base !== 4) $display("FAIL ovf_count: got %0d want 4", wr_log.size() - base); else n_pass++;
    n_checks++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b want 1", overflow); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL ovf_frame_done: got %0d want 1", done_cnt - d0); else n_pass++;
    full_at = 0;
    base = wr_log.size();
    send_frame(4, 8, 8'hF8, 8'h00);
    first = (wr_log.size() > base) ? wr_log[base] : 17'h0;
    n_checks++; if (wr_log.size() - base !== 32) $display("FAIL ovf_next_count: got %0d want 32", wr_log.size() - base); else n_pass++;
    n_checks++; if (first !== 17'h1F800) $display("FAIL ovf_next_sof: got %h want 1f800", first); else n_pass++;
    n_checks++; if (overflow !== 1'b0) $display("FAIL ovf_cleared: got %b want 0", overflow); else n_pass++;
  endtask

  task automatic test_enable_drop();
    int base, d0;
    base = wr_log.size(); d0 = done_cnt;
    frame_start();
    send_line(8, 8'hF8, 8'h00);
    send_line(8, 8'hF8, 8'h00);
    enable = 1'b0;
    send_line(8, 8'hF8, 8'h00);
    send_line(8, 8'hF8, 8'h00);
    frame_end();
    n_checks++; if (wr_log.size() - base !== 32) $display("FAIL endrop_count: got %0d want 32", wr_log.size() - base); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 1) $display("FAIL endrop_frame_done: got %0d want 1", done_cnt - d0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL endrop_idle: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_enable_raise();
    int base, d0;
    logic [16:0] first;
    base = wr_log.size(); d0 = done_cnt;
    frame_start();
    send_line(8, 8'hF8, 8'h00);
    send_line(8, 8'hF8, 8'h00);
    enable = 1'b1;
    send_line(8, 8'hF8, 8'h00);
    send_line(8, 8'hF8, 8'h00);
    frame_end();
    n_checks++; if (wr_log.size() - base !== 0) $display("FAIL enraise_midframe: got %0d writes want 0", wr_log.size() - base); else n_pass++;
    n_checks++; if (done_cnt - d0 !== 0) $display("FAIL enraise_frame_done: got %0d want 0", done_cnt - d0); else n_pass++;
    base = wr_log.size();
    send_frame(4, 8, 8'hF8, 8'h00);
    first = (wr_log.size() > base) ? wr_log[base] : 17'h0;
    n_checks++; if (wr_log.size() - base !== 32) $display("FAIL enraise_next_count: got %0d want 32", wr_log.size() - base); else n_pass++;
    n_checks++; if (first !== 17'h1F800) $display("FAIL enraise_next_sof: got %h want 1f800", first); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int base;
    logic [16:0] first;
    frame_start();
    send_line(8, 8'hF8, 8'h00);
    for (int p = 0; p < 2; p++) begin
      @(negedge clk); cam_href = 1'b1; cam_data = 8'hF8;
      @(negedge clk); cam_data = 8'h00;
    end
    @(negedge clk); cam_data = 8'hF8;
    reset_n = 1'b0;
    #1;
    n_checks++; if (queue_wr_en !== 1'b0) $display("FAIL rstmid_wr_en: got %b want 0", queue_wr_en); else n_pass++;
    n_checks++; if (queue_data !== 17'h0) $display("FAIL rstmid_data: got %h want 00000", queue_data); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b want 0", busy); else n_pass++;
    base = wr_log.size();
    @(negedge clk); cam_data = 8'h00;
    @(negedge clk); reset_n = 1'b1;
    for (int p = 0; p < 5; p++) begin
      @(negedge clk); cam_data = 8'hF8;
      @(negedge clk); cam_data = 8'h00;
    end
    @(negedge clk); cam_href = 1'b0;
    repeat (3) @(negedge clk);
    send_line(8, 8'hF8, 8'h00);
    send_line(8, 8'hF8, 8'h00);
    frame_end();
    n_checks++; if (wr_log.size() - base !== 0) $display("FAIL rstmid_resume: got %0d writes want 0", wr_log.size() - base); else n_pass++;
    base = wr_log.size();
    send_frame(4, 8, 8'hF8, 8'h00);
    first = (wr_log.size() > base) ? wr_log[base] : 17'h0;
    n_checks++; if (wr_log.size() - base !== 32) $display("FAIL rstmid_next_count: got %0d want 32", wr_log.size() - base); else n_pass++;
    n_checks++; if (first !== 17'h1F800) $display("FAIL rstmid_next_sof: got %h want 1f800", first); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_latency();
    test_oversize();
    test_overflow();
    test_enable_drop();
    test_enable_raise();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
